rr_dest_scheduler: RTL and testbench

Destination-aware round-robin scheduler for the 4-in/4-out FIFO switch. It watches the head word of four first-word-fall-through input FIFOs and routes each word to the output FIFO named by its destination field. It grants one input per cycle under rotating priority, skipping inputs whose destination output FIFO is almost full. It replaces fixed-priority selection and owns all pop/push sequencing between the two FIFO banks.

---
 rtl/rr_dest_scheduler_pkg.sv | 24 ++
 rtl/rr_dest_scheduler_if.sv | 33 +++
 rtl/rr_dest_scheduler_pick4.sv | 35 +++
 rtl/rr_dest_scheduler.sv | 131 +++++++++++++
 tb/tb_rr_dest_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_dest_scheduler_pkg.sv
// Shared parameters, FSM encoding and word-field helpers for the
// destination-aware round-robin scheduler.
package rr_dest_scheduler_pkg;

    localparam int DATA_W   = 10;
    localparam int DEST_LSB = 8;
    localparam int CNT_W    = 8;
    localparam int N_PORTS  = 4;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] word);
        return 2'(word >> DEST_LSB);
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_dest_scheduler_if.sv
// Bundle of input-FIFO, output-FIFO and status signals between the
// FIFO banks (master) and the scheduler (slave).
interface rr_dest_scheduler_if;
    import rr_dest_scheduler_pkg::*;

    logic                enable;
    logic [3:0]          empty_in;
    logic [DATA_W-1:0]   head_0;
    logic [DATA_W-1:0]   head_1;
    logic [DATA_W-1:0]   head_2;
    logic [DATA_W-1:0]   head_3;
    logic [3:0]          afull_out;
    logic [3:0]          pop;
    logic [3:0]          push;
    logic [DATA_W-1:0]   data_out;
    logic [1:0]          grant_id;
    logic                idle;
    logic [CNT_W-1:0]    cnt_0;
    logic [CNT_W-1:0]    cnt_1;
    logic [CNT_W-1:0]    cnt_2;
    logic [CNT_W-1:0]    cnt_3;

    modport master (
        output enable, empty_in, head_0, head_1, head_2, head_3, afull_out,
        input  pop, push, data_out, grant_id, idle, cnt_0, cnt_1, cnt_2, cnt_3
    );

    modport slave (
        input  enable, empty_in, head_0, head_1, head_2, head_3, afull_out,
        output pop, push, data_out, grant_id, idle, cnt_0, cnt_1, cnt_2, cnt_3
    );

endinterface

// File: rtl/rr_dest_scheduler_pick4.sv
// Combinational 4-way rotating-priority picker: the first requester at or
// after i_ptr (wrapping 3->0) wins.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_any
);

    logic [3:0] w_rot;
    logic [1:0] w_off;

    // Rotate so that bit 0 is the requester at the pointer position.
    assign w_rot = (i_req >> i_ptr) | (i_req << (3'd4 - {1'b0, i_ptr}));

    // Lowest set bit of the rotated vector is the offset from the pointer.
    always_comb begin
        w_off = 2'd3;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else begin
            w_off = 2'd3;
        end
    end

    assign o_any    = |i_req;
    assign o_gnt_id = i_ptr + w_off;
    assign o_gnt    = o_any ? (4'b0001 << o_gnt_id) : 4'b0000;

endmodule

// File: rtl/rr_dest_scheduler.sv
// Destination-aware round-robin scheduler: pops one eligible input FIFO per
// cycle and pushes the word into its destination output FIFO one cycle later.
module rr_dest_scheduler
    import rr_dest_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    rr_dest_scheduler_if.slave bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [1:0]          r_ptr;
    logic                r_vld;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_dest;
    logic [CNT_W-1:0]    r_cnt [N_PORTS];

    logic [DATA_W-1:0]   w_head [N_PORTS];
    logic [3:0]          w_req;
    logic [3:0]          w_gnt;
    logic [1:0]          w_gnt_id;
    logic                w_any;
    logic                w_arb_en;
    logic                w_grant;
    logic [3:0]          w_pop;

    assign w_head[0] = bus.head_0;
    assign w_head[1] = bus.head_1;
    assign w_head[2] = bus.head_2;
    assign w_head[3] = bus.head_3;

    // An input is eligible when it holds a word whose output has room.
    always_comb begin
        w_req = 4'b0000;
        for (int k = 0; k < N_PORTS; k++) begin
            w_req[k] = !bus.empty_in[k] && !bus.afull_out[dest_of(w_head[k])];
        end
    end

    rr_pick4 u_pick (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: every state follows enable once INIT has elapsed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    w_state_nxt = bus.enable ? RUN : DRAIN;
            RUN:     w_state_nxt = bus.enable ? RUN : DRAIN;
            DRAIN:   w_state_nxt = bus.enable ? RUN : DRAIN;
            default: w_state_nxt = INIT;
        endcase
    end

    // FSM outputs: only RUN may pop; grant_id reads 0 when nothing is granted.
    always_comb begin
        w_arb_en = 1'b0;
        case (r_state)
            RUN:     w_arb_en = 1'b1;
            INIT:    w_arb_en = 1'b0;
            DRAIN:   w_arb_en = 1'b0;
            default: w_arb_en = 1'b0;
        endcase
        w_grant = w_arb_en && w_any;
        if (w_grant) begin
            w_pop        = w_gnt;
            bus.grant_id = w_gnt_id;
        end else begin
            w_pop        = 4'b0000;
            bus.grant_id = 2'd0;
        end
    end

    // Stage register and rotating pointer, loaded on the grant edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr  <= 2'd0;
            r_vld  <= 1'b0;
            r_data <= {DATA_W{1'b0}};
            r_dest <= 2'd0;
        end else if (w_grant) begin
            r_ptr  <= w_gnt_id + 2'd1;
            r_vld  <= 1'b1;
            r_data <= w_head[w_gnt_id];
            r_dest <= dest_of(w_head[w_gnt_id]);
        end else begin
            r_vld  <= 1'b0;
        end
    end

    // Per-output push counters; they wrap naturally at their width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_PORTS; k++) begin
                r_cnt[k] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (r_vld && (r_dest == 2'(k))) begin
                    r_cnt[k] <= r_cnt[k] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[k] <= r_cnt[k];
                end
            end
        end
    end

    assign bus.pop      = w_pop;
    assign bus.push     = r_vld ? onehot4(r_dest) : 4'b0000;
    assign bus.data_out = r_data;
    assign bus.idle     = !r_vld && !(|w_pop);
    assign bus.cnt_0    = r_cnt[0];
    assign bus.cnt_1    = r_cnt[1];
    assign bus.cnt_2    = r_cnt[2];
    assign bus.cnt_3    = r_cnt[3];

endmodule

// File: tb/tb_rr_dest_scheduler.sv
// Self-checking bench: input FIFOs are modelled as queues, and a
// reference scheduler predicts pops, pushes and counters every cycle.
module tb_rr_dest_scheduler;
    import rr_dest_scheduler_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rr_dest_scheduler_if bus();
    rr_dest_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] fq [4][$];
    logic [3:0]        afull_v = 4'b0000;
    logic              en_v    = 1'b1;

    bit                m_after_init;
    bit                m_en_last;
    bit                m_vld;
    logic [DATA_W-1:0] m_data;
    int                m_dest;
    int                m_ptr;
    int                m_cnt [4];

    bit                e_grant;
    int                e_gid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dest_field(input logic [DATA_W-1:0] w);
        return int'(w[DEST_LSB +: 2]);
    endfunction

    task automatic model_reset();
        m_after_init = 1'b0;
        m_en_last    = 1'b0;
        m_vld        = 1'b0;
        m_data       = '0;
        m_dest       = 0;
        m_ptr        = 0;
        for (int n = 0; n < 4; n++) begin
            m_cnt[n] = 0;
            fq[n].delete();
        end
    endtask

    task automatic drive();
        logic [DATA_W-1:0] hd [4];
        for (int n = 0; n < 4; n++) begin
            hd[n] = (fq[n].size() > 0) ? fq[n][0] : DATA_W'($urandom);
            bus.empty_in[n] = (fq[n].size() == 0);
        end
        bus.head_0    = hd[0];
        bus.head_1    = hd[1];
        bus.head_2    = hd[2];
        bus.head_3    = hd[3];
        bus.enable    = en_v;
        bus.afull_out = afull_v;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pop"},  32'(bus.pop),      32'(0));
        check({tag, "_push"}, 32'(bus.push),     32'(0));
        check({tag, "_data"}, 32'(bus.data_out), 32'(0));
        check({tag, "_gid"},  32'(bus.grant_id), 32'(0));
        check({tag, "_idle"}, 32'(bus.idle),     32'(1));
        check({tag, "_cnt0"}, 32'(bus.cnt_0),    32'(0));
        check({tag, "_cnt1"}, 32'(bus.cnt_1),    32'(0));
        check({tag, "_cnt2"}, 32'(bus.cnt_2),    32'(0));
        check({tag, "_cnt3"}, 32'(bus.cnt_3),    32'(0));
    endtask

    // One clock cycle: drive at negedge, predict and compare, then advance the model.
    task automatic cycle();
        logic [3:0] e_pop;
        logic [3:0] e_push;
        drive();
        #1;
        e_grant = 1'b0;
        e_gid   = 0;
        if (m_after_init && m_en_last) begin
            for (int i = 0; i < 4; i++) begin
                int n;
                n = (m_ptr + i) % 4;
                if (!e_grant && fq[n].size() > 0 && !afull_v[dest_field(fq[n][0])]) begin
                    e_grant = 1'b1;
                    e_gid   = n;
                end
            end
        end
        e_pop  = e_grant ? (4'b0001 << e_gid) : 4'b0000;
        e_push = m_vld ? (4'b0001 << m_dest) : 4'b0000;
        check("pop",  32'(bus.pop),  32'(e_pop));
        if (e_grant) check("grant_id", 32'(bus.grant_id), 32'(e_gid));
        check("push", 32'(bus.push), 32'(e_push));
        if (m_vld) check("data_out", 32'(bus.data_out), 32'(m_data));
        check("idle", 32'(bus.idle), 32'(!m_vld && !e_grant));
        check("cnt_0", 32'(bus.cnt_0), 32'(m_cnt[0]));
        check("cnt_1", 32'(bus.cnt_1), 32'(m_cnt[1]));
        check("cnt_2", 32'(bus.cnt_2), 32'(m_cnt[2]));
        check("cnt_3", 32'(bus.cnt_3), 32'(m_cnt[3]));
        @(posedge clk);
        if (m_vld) m_cnt[m_dest] = (m_cnt[m_dest] + 1) % 256;
        if (e_grant) begin
            m_data = fq[e_gid].pop_front();
            m_dest = dest_field(m_data);
            m_vld  = 1'b1;
            m_ptr  = (e_gid + 1) % 4;
        end else begin
            m_vld  = 1'b0;
        end
        m_after_init = 1'b1;
        m_en_last    = en_v;
        @(negedge clk);
    endtask

    task automatic run_until_drained(input int max_cycles);
        int used;
        bit busy;
        used = 0;
        busy = 1'b1;
        while (busy && used < max_cycles) begin
            cycle();
            used++;
            busy = m_vld || fq[0].size() > 0 || fq[1].size() > 0 ||
                   fq[2].size() > 0 || fq[3].size() > 0;
        end
        check("drain_bound", 32'(busy), 32'(0));
    endtask

    initial begin
        model_reset();
        drive();
        #2 reset = 1'b0;
        #1 check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;

        // Single word 0x200 from input 0 to output 2.
        fq[0].push_back(10'h200);
        run_until_drained(10);
        check("single_cnt2", 32'(bus.cnt_2), 32'(1));

        // Fairness: three dest-0 words on every input.
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 4; n++)
                fq[n].push_back(10'(n * 16 + k));
        run_until_drained(30);
        check("fair_cnt0", 32'(bus.cnt_0), 32'(12));

        // Backpressure: output 1 almost full holds input 0, input 1 proceeds.
        afull_v = 4'b0010;
        fq[0].push_back(10'h1AA);
        fq[1].push_back(10'h3BB);
        repeat (5) cycle();
        afull_v = 4'b0000;
        run_until_drained(10);

        // Enable drop in the same cycle as a grant, then resume.
        for (int n = 0; n < 4; n++) begin
            fq[n].push_back(DATA_W'($urandom));
            fq[n].push_back(DATA_W'($urandom));
        end
        cycle();
        en_v = 1'b0;
        cycle();
        repeat (3) cycle();
        check("drain_idle", 32'(bus.idle), 32'(1));
        en_v = 1'b1;
        run_until_drained(30);

        // Async reset between pop and push.
        fq[2].push_back(10'h1C5);
        cycle();
        check("pre_reset_push", 32'(bus.push), 32'(4'b0010));
        reset = 1'b0;
        #1 check_reset_vals("midflight");
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Counter wrap: 256 words to output 3.
        for (int k = 0; k < 64; k++)
            for (int n = 0; n < 4; n++)
                fq[n].push_back(10'h300 | 10'(k));
        run_until_drained(300);
        check("wrap_cnt3", 32'(bus.cnt_3), 32'(0));

        // Randomized traffic with random backpressure and enable.
        for (int c = 0; c < 500; c++) begin
            for (int n = 0; n < 4; n++)
                if (fq[n].size() < 4 && $urandom_range(0, 2) == 0)
                    fq[n].push_back(DATA_W'($urandom));
            for (int n = 0; n < 4; n++)
                afull_v[n] = ($urandom_range(0, 3) == 0);
            en_v = ($urandom_range(0, 9) != 0);
            cycle();
        end
        afull_v = 4'b0000;
        en_v    = 1'b1;
        run_until_drained(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
